tcam_cmd_issuer: RTL and testbench
==================================

# tcam_cmd_issuer

Hardware initiator for the TCAM neuron memory (`Mem`) command bus. It accepts single or burst requests on a valid/ready port and sequences them onto the memory's `MODE`/data/mask/address/flag signals. Each command is framed as one or more active cycles followed by one idle cycle. For reads it waits for the memory's read data and returns it on a response port. It replaces bench-task sequencing with synthesizable control, so a packet router or host bridge can drive the memory directly.

## Interface
Parameters:
- `ID_Width`, 4, packet/destination ID field width
- `AddressSize`, 4, memory address width
- `Bits`, 8, entry data/mask width (must be ≥ 2·`ID_Width`)
- `RD_LAT`, 1, cycles from `MODE_R` issue to valid `Mem_Rd_Data` (range 1–7)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `Req_Valid` in 1: request present
- `Req_Ready` out 1: request accepted when high with `Req_Valid`
- `Req_Mode` in 3: `MODE_*` command code
- `Req_Data` in `Bits`: write/compare data; for fire, `[ID_Width-1:0]` is the PacketID
- `Req_Mskb` in `Bits`: mask
- `Req_A` in `AddressSize`: start address
- `Req_Dcs`, `Req_Vbe`, `Req_Vbi` in 1 each: flags passed to the memory
- `Req_Len` in 5: beat count; 0 is treated as 1
- `Req_Inc` in 1: increment data per beat
- `MODE` out 3: command to memory
- `Data_Out` out `Bits`
- `Mskb_Out` out `Bits`
- `A_Out` out `AddressSize`
- `Dcs_Out`, `Vbe_Out`, `Vbi_Out` out 1 each
- `PacketID_Out` out `ID_Width`
- `Mem_Rd_Data` in `Bits`: read data from memory
- `Mem_Vbo` in 1: valid bit read from memory
- `Rsp_Valid` out 1: read response present
- `Rsp_Ready` in 1: response consumed
- `Rsp_Data` out `Bits`
- `Rsp_Vbo` out 1
- `Rsp_A` out `AddressSize`: address the response belongs to

## Operation
Mode codes:
- I=000, W=001, R=010, F=011, C=100, RST=101.
- 110 and 111 are illegal.

States: IDLE, ISSUE, RDWAIT, RESP, GAP.

- **IDLE**
  - `Req_Ready`=1, and the bus is at idle values.
  - On a handshake, latch all request fields and set the beat counter to `max(Req_Len,1)`.
  - Modes W/F/C/R/RST go to ISSUE.
  - Modes I, 110 and 111 are accepted and dropped; the FSM stays in IDLE and nothing is issued.
- **ISSUE**, one cycle per beat. The latched command is driven on the bus.
  - W: `MODE`=W with Data/Mskb/A/Dcs/Vbe/Vbi.
    - Next beat: A+1.
    - If Inc: both `Data[Bits-1 -: ID_Width]` and `Data[ID_Width-1:0]` increment by 1, each field wrapping independently.
  - C: `MODE`=C with Data/Mskb. Next beat: Data+1 (full width) if Inc.
  - F: `MODE`=F with `PacketID_Out`=`Data[ID_Width-1:0]`. Next beat: +1 if Inc.
  - R: `MODE`=R with A/Dcs/Vbe, then go to RDWAIT.
  - RST: `MODE`=RST with `PacketID_Out`=0. Exactly one beat; `Req_Len` is ignored.
  - After the last beat of W/F/C/RST, go to GAP.
- **RDWAIT**
  - Drives `MODE`=I and counts `RD_LAT` cycles.
  - Captures `Mem_Rd_Data`/`Mem_Vbo` into the response register, then goes to RESP.
- **RESP**
  - Holds `Rsp_Valid`=1 with stable data until `Rsp_Ready`.
  - On acceptance, if beats remain: A+1, then ISSUE. Otherwise go to GAP.
- **GAP**
  - One cycle of idle values: `MODE`=I; Data, Mskb, A, Vbe, Vbi = 0; `Dcs_Out` holds the last command's Dcs.
  - Then go to IDLE.
- Address and data arithmetic wraps modulo 2^width; an address burst wraps from `{AddressSize{1'b1}}` to 0.

## Timing
- Reset values:
  - `MODE`=I, all bus outputs 0, `PacketID_Out`=0.
  - `Rsp_Valid`=0, `Rsp_*`=0.
  - `Req_Ready`=1, FSM in IDLE.
- All outputs are registered except `Req_Ready`, which is decoded from the IDLE state.
- The first bus beat appears the cycle after the request handshake.
- An N-beat W/F/C occupies N+1 cycles after acceptance. The next request can be accepted in the cycle after GAP.
- Read beat cost is 1 + `RD_LAT` + (cycles waiting for `Rsp_Ready`).
  - With `Rsp_Ready` held high, a read's response is valid `RD_LAT`+1 cycles after its issue cycle.
  - The next read issues the cycle after acceptance.
- Asserting `rst_n` low mid-burst immediately returns every output to its reset value, drops the pending response, and abandons the burst.

## Configuration
- `TCAM_CMD_COUNT_EN` defined:
  - Adds output `Cmd_Count` (16 bits, reset 0).
  - Increments once per ISSUE cycle and wraps at 0xFFFF→0.
  - A synchronous `Cmd_Count_Clr` input has priority over the increment.
- Not defined: neither port exists and no counter logic is present.

## Structure
- `tcam_pkg` holds:
  - the `MODE_*` localparams and a `tcam_mode_e` enum,
  - the `issuer_state_e` FSM enum,
  - `ZERO_*` constants.
- One sub-module, `tcam_beat_step`: combinational next-beat generator (address +1, ID-field increments, full-data increment) selected by mode and Inc.

## Test plan
- Reset, then W Data=0x00, Mskb=0xFF, A=1, Dcs=Vbe=Vbi=1, Len=1 → one cycle `MODE`=001 with A=1, then one cycle `MODE`=000 with Vbe=0, Dcs=1; `Req_Ready` returns to 1.
- W Data=0x31, A=0xE, Len=3, Inc=1 → beats (A,Data) = (E,31), (F,42), (0,53); then a GAP cycle.
- R A=1, Len=2, `RD_LAT`=2, `Mem_Rd_Data`=0xA5, `Rsp_Ready` held low 3 cycles → `Rsp_Valid` stable with Data=A5, A=1; second read issues at A=2 only after acceptance.
- F Data=0x0E, Len=3, Inc=1 → `PacketID_Out` = E, F, 0 on consecutive `MODE`=011 cycles.
- Req_Mode=111 → accepted, no non-idle `MODE` cycle; RST request → one `MODE`=101 cycle with PacketID=0, then GAP.
- `rst_n` low during beat 2 of a Len=4 C burst → outputs go to reset values immediately; after release, IDLE with `Req_Ready`=1; `Cmd_Count`=2 is cleared to 0 (with `TCAM_CMD_COUNT_EN`).

Source files
------------

// File: rtl/tcam_pkg.sv
// Command codes, issuer FSM states and idle-bus constants shared by the TCAM
// command issuer and its beat stepper.
package tcam_pkg;

   localparam logic [2:0] MODE_I   = 3'b000;
   localparam logic [2:0] MODE_W   = 3'b001;
   localparam logic [2:0] MODE_R   = 3'b010;
   localparam logic [2:0] MODE_F   = 3'b011;
   localparam logic [2:0] MODE_C   = 3'b100;
   localparam logic [2:0] MODE_RST = 3'b101;

   typedef enum logic [2:0] {
      TM_I   = MODE_I,
      TM_W   = MODE_W,
      TM_R   = MODE_R,
      TM_F   = MODE_F,
      TM_C   = MODE_C,
      TM_RST = MODE_RST
   } tcam_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RDWAIT,
      ST_RESP,
      ST_GAP
   } issuer_state_e;

   localparam logic [2:0]  ZERO_MODE  = MODE_I;
   localparam logic        ZERO_FLAG  = 1'b0;
   localparam logic [15:0] ZERO_COUNT = 16'd0;

   // I and the two unassigned codes are swallowed at the request port.
   function automatic logic is_cmd(input logic [2:0] m);
      return (m == MODE_W) || (m == MODE_R) || (m == MODE_F) ||
             (m == MODE_C) || (m == MODE_RST);
   endfunction

endpackage

// File: rtl/tcam_beat_step.sv
// Combinational next-beat generator: address, ID-field and full-data increments
// selected by the latched command mode and its increment flag.
module tcam_beat_step
   import tcam_pkg::*;
#(
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 8
) (
   input  logic [2:0]             mode,
   input  logic                   inc,
   input  logic [Bits-1:0]        data,
   input  logic [AddressSize-1:0] a,
   output logic [Bits-1:0]        data_nxt,
   output logic [AddressSize-1:0] a_nxt
);

   logic [ID_Width-1:0] hi_inc;
   logic [ID_Width-1:0] lo_inc;

   assign hi_inc = data[Bits-1 -: ID_Width] + ID_Width'(1);
   assign lo_inc = data[ID_Width-1:0] + ID_Width'(1);

   always_comb begin
      data_nxt = data;
      a_nxt    = a;
      case (tcam_mode_e'(mode))
         TM_W: begin
            a_nxt = a + AddressSize'(1);
            // The two ID fields of a write entry step independently.
            if (inc) begin
               data_nxt[Bits-1 -: ID_Width] = hi_inc;
               data_nxt[ID_Width-1:0]       = lo_inc;
            end
         end
         TM_C: if (inc) data_nxt = data + Bits'(1);
         TM_F: if (inc) data_nxt[ID_Width-1:0] = lo_inc;
         TM_R: a_nxt = a + AddressSize'(1);
         default: ;
      endcase
   end

endmodule

// File: rtl/tcam_cmd_issuer.sv
// Sequences valid/ready requests onto the TCAM Mem bus (beats, idle gap, read wait/response).
// Bus outputs registered, first beat one cycle after handshake; optional TCAM_CMD_COUNT_EN beat counter.
module tcam_cmd_issuer
   import tcam_pkg::*;
#(
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 8,
   parameter int RD_LAT      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   Req_Valid,
   output logic                   Req_Ready,
   input  logic [2:0]             Req_Mode,
   input  logic [Bits-1:0]        Req_Data,
   input  logic [Bits-1:0]        Req_Mskb,
   input  logic [AddressSize-1:0] Req_A,
   input  logic                   Req_Dcs,
   input  logic                   Req_Vbe,
   input  logic                   Req_Vbi,
   input  logic [4:0]             Req_Len,
   input  logic                   Req_Inc,
   output logic [2:0]             MODE,
   output logic [Bits-1:0]        Data_Out,
   output logic [Bits-1:0]        Mskb_Out,
   output logic [AddressSize-1:0] A_Out,
   output logic                   Dcs_Out,
   output logic                   Vbe_Out,
   output logic                   Vbi_Out,
   output logic [ID_Width-1:0]    PacketID_Out,
   input  logic [Bits-1:0]        Mem_Rd_Data,
   input  logic                   Mem_Vbo,
   output logic                   Rsp_Valid,
   input  logic                   Rsp_Ready,
   output logic [Bits-1:0]        Rsp_Data,
   output logic                   Rsp_Vbo,
   output logic [AddressSize-1:0] Rsp_A
`ifdef TCAM_CMD_COUNT_EN
   ,
   input  logic                   Cmd_Count_Clr,
   output logic [15:0]            Cmd_Count
`endif
);

   issuer_state_e          state, state_nxt;
   logic [2:0]             cur_mode, mode_nxt;
   logic [Bits-1:0]        cur_data, data_nxt, cur_mskb, mskb_nxt, step_data;
   logic [AddressSize-1:0] cur_a, a_nxt, step_a;
   logic                   cur_dcs, dcs_nxt, cur_vbe, vbe_nxt, cur_vbi, vbi_nxt;
   logic                   cur_inc, inc_nxt;
   logic [4:0]             beats, beats_nxt;
   logic [2:0]             rd_cnt, rd_cnt_nxt;
   logic                   rsp_cap, rsp_done;

   logic [2:0]             bus_mode;
   logic [Bits-1:0]        bus_data, bus_mskb;
   logic [AddressSize-1:0] bus_a;
   logic                   bus_dcs, bus_vbe, bus_vbi;
   logic [ID_Width-1:0]    bus_pid;

   assign Req_Ready = (state == ST_IDLE);
   assign rsp_done  = (state == ST_RESP) && Rsp_Ready;

   tcam_beat_step #(
      .ID_Width    (ID_Width),
      .AddressSize (AddressSize),
      .Bits        (Bits)
   ) u_step (
      .mode     (cur_mode),
      .inc      (cur_inc),
      .data     (cur_data),
      .a        (cur_a),
      .data_nxt (step_data),
      .a_nxt    (step_a)
   );

   always_comb begin
      state_nxt  = state;
      mode_nxt   = cur_mode;
      data_nxt   = cur_data;
      mskb_nxt   = cur_mskb;
      a_nxt      = cur_a;
      dcs_nxt    = cur_dcs;
      vbe_nxt    = cur_vbe;
      vbi_nxt    = cur_vbi;
      inc_nxt    = cur_inc;
      beats_nxt  = beats;
      rd_cnt_nxt = rd_cnt;
      rsp_cap    = 1'b0;
      case (state)
         ST_IDLE: if (Req_Valid) begin
            mode_nxt  = Req_Mode;
            data_nxt  = Req_Data;
            mskb_nxt  = Req_Mskb;
            a_nxt     = Req_A;
            dcs_nxt   = Req_Dcs;
            vbe_nxt   = Req_Vbe;
            vbi_nxt   = Req_Vbi;
            inc_nxt   = Req_Inc;
            beats_nxt = (Req_Mode == MODE_RST || Req_Len == 5'd0) ? 5'd1 : Req_Len;
            if (is_cmd(Req_Mode)) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (cur_mode == MODE_R) begin
               state_nxt  = ST_RDWAIT;
               rd_cnt_nxt = 3'(RD_LAT);
            end else if (beats == 5'd1) begin
               state_nxt = ST_GAP;
            end else begin
               beats_nxt = beats - 5'd1;
               data_nxt  = step_data;
               a_nxt     = step_a;
            end
         end
         ST_RDWAIT: begin
            // Read data is valid in the last wait cycle; capture it on leaving.
            if (rd_cnt == 3'd1) begin
               rsp_cap   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               rd_cnt_nxt = rd_cnt - 3'd1;
            end
         end
         ST_RESP: if (Rsp_Ready) begin
            if (beats > 5'd1) begin
               beats_nxt = beats - 5'd1;
               a_nxt     = step_a;
               state_nxt = ST_ISSUE;
            end else begin
               state_nxt = ST_GAP;
            end
         end
         ST_GAP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus values for the coming cycle; Dcs holds its last command value when idle.
   always_comb begin
      bus_mode = ZERO_MODE;
      bus_data = '0;
      bus_mskb = '0;
      bus_a    = '0;
      bus_dcs  = Dcs_Out;
      bus_vbe  = ZERO_FLAG;
      bus_vbi  = ZERO_FLAG;
      bus_pid  = '0;
      if (state_nxt == ST_ISSUE) begin
         bus_mode = mode_nxt;
         bus_dcs  = dcs_nxt;
         case (mode_nxt)
            MODE_W: begin
               bus_data = data_nxt;
               bus_mskb = mskb_nxt;
               bus_a    = a_nxt;
               bus_vbe  = vbe_nxt;
               bus_vbi  = vbi_nxt;
            end
            MODE_C: begin
               bus_data = data_nxt;
               bus_mskb = mskb_nxt;
            end
            MODE_F: bus_pid = data_nxt[ID_Width-1:0];
            MODE_R: begin
               bus_a   = a_nxt;
               bus_vbe = vbe_nxt;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cur_mode     <= ZERO_MODE;
         cur_data     <= '0;
         cur_mskb     <= '0;
         cur_a        <= '0;
         cur_dcs      <= ZERO_FLAG;
         cur_vbe      <= ZERO_FLAG;
         cur_vbi      <= ZERO_FLAG;
         cur_inc      <= ZERO_FLAG;
         beats        <= '0;
         rd_cnt       <= '0;
         MODE         <= ZERO_MODE;
         Data_Out     <= '0;
         Mskb_Out     <= '0;
         A_Out        <= '0;
         Dcs_Out      <= ZERO_FLAG;
         Vbe_Out      <= ZERO_FLAG;
         Vbi_Out      <= ZERO_FLAG;
         PacketID_Out <= '0;
         Rsp_Valid    <= ZERO_FLAG;
         Rsp_Data     <= '0;
         Rsp_Vbo      <= ZERO_FLAG;
         Rsp_A        <= '0;
      end else begin
         state        <= state_nxt;
         cur_mode     <= mode_nxt;
         cur_data     <= data_nxt;
         cur_mskb     <= mskb_nxt;
         cur_a        <= a_nxt;
         cur_dcs      <= dcs_nxt;
         cur_vbe      <= vbe_nxt;
         cur_vbi      <= vbi_nxt;
         cur_inc      <= inc_nxt;
         beats        <= beats_nxt;
         rd_cnt       <= rd_cnt_nxt;
         MODE         <= bus_mode;
         Data_Out     <= bus_data;
         Mskb_Out     <= bus_mskb;
         A_Out        <= bus_a;
         Dcs_Out      <= bus_dcs;
         Vbe_Out      <= bus_vbe;
         Vbi_Out      <= bus_vbi;
         PacketID_Out <= bus_pid;
         if (rsp_cap) begin
            Rsp_Valid <= 1'b1;
            Rsp_Data  <= Mem_Rd_Data;
            Rsp_Vbo   <= Mem_Vbo;
            Rsp_A     <= cur_a;
         end else if (rsp_done) begin
            Rsp_Valid <= 1'b0;
         end
      end
   end

`ifdef TCAM_CMD_COUNT_EN
   // Counts in step with the bus, so it already includes the beat being driven.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      Cmd_Count <= ZERO_COUNT;
      else if (Cmd_Count_Clr)          Cmd_Count <= ZERO_COUNT;
      else if (state_nxt == ST_ISSUE)  Cmd_Count <= Cmd_Count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_tcam_cmd_issuer.sv
// Randomized and directed stimulus for tcam_cmd_issuer, checked cycle by cycle
// against a transaction-level model of the command framing and a read-latency memory.
module tb_tcam_cmd_issuer;

   localparam int IDW = 4;
   localparam int AW  = 4;
   localparam int BW  = 8;
   localparam int RDL = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          Req_Valid, Req_Ready;
   logic [2:0]    Req_Mode;
   logic [BW-1:0] Req_Data, Req_Mskb;
   logic [AW-1:0] Req_A;
   logic          Req_Dcs, Req_Vbe, Req_Vbi, Req_Inc;
   logic [4:0]    Req_Len;
   logic [2:0]    MODE;
   logic [BW-1:0] Data_Out, Mskb_Out;
   logic [AW-1:0] A_Out;
   logic          Dcs_Out, Vbe_Out, Vbi_Out;
   logic [IDW-1:0] PacketID_Out;
   logic [BW-1:0] Mem_Rd_Data;
   logic          Mem_Vbo;
   logic          Rsp_Valid, Rsp_Ready, Rsp_Vbo;
   logic [BW-1:0] Rsp_Data;
   logic [AW-1:0] Rsp_A;
`ifdef TCAM_CMD_COUNT_EN
   logic          Cmd_Count_Clr = 1'b0;
   logic [15:0]   Cmd_Count;
   int            cnt0;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [BW-1:0] mem_d [16];
   logic          mem_v [16];
   logic          hv [8] = '{default: 1'b0};
   logic [AW-1:0] ha [8] = '{default: '0};

   always #5 clk = ~clk;

   tcam_cmd_issuer #(
      .ID_Width (IDW), .AddressSize (AW), .Bits (BW), .RD_LAT (RDL)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .Req_Valid (Req_Valid), .Req_Ready (Req_Ready), .Req_Mode (Req_Mode),
      .Req_Data (Req_Data), .Req_Mskb (Req_Mskb), .Req_A (Req_A),
      .Req_Dcs (Req_Dcs), .Req_Vbe (Req_Vbe), .Req_Vbi (Req_Vbi),
      .Req_Len (Req_Len), .Req_Inc (Req_Inc),
      .MODE (MODE), .Data_Out (Data_Out), .Mskb_Out (Mskb_Out), .A_Out (A_Out),
      .Dcs_Out (Dcs_Out), .Vbe_Out (Vbe_Out), .Vbi_Out (Vbi_Out),
      .PacketID_Out (PacketID_Out),
      .Mem_Rd_Data (Mem_Rd_Data), .Mem_Vbo (Mem_Vbo),
      .Rsp_Valid (Rsp_Valid), .Rsp_Ready (Rsp_Ready), .Rsp_Data (Rsp_Data),
      .Rsp_Vbo (Rsp_Vbo), .Rsp_A (Rsp_A)
`ifdef TCAM_CMD_COUNT_EN
      , .Cmd_Count_Clr (Cmd_Count_Clr), .Cmd_Count (Cmd_Count)
`endif
   );

   // Memory: read data for a MODE_R issued at cycle t is valid in cycle t+RDL, junk otherwise.
   always @(negedge clk) begin
      for (int i = 7; i > 0; i--) begin
         hv[i] = hv[i-1];
         ha[i] = ha[i-1];
      end
      hv[0] = (MODE == 3'b010);
      ha[0] = A_Out;
      if (hv[RDL]) begin
         Mem_Rd_Data = mem_d[ha[RDL]];
         Mem_Vbo     = mem_v[ha[RDL]];
      end else begin
         Mem_Rd_Data = BW'($urandom);
         Mem_Vbo     = 1'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int w_data(input int d, input int step);
      int msk, hi, lo;
      msk = (1 << IDW) - 1;
      hi  = ((d >> (BW - IDW)) + step) & msk;
      lo  = ((d & msk) + step) & msk;
      return (d & ~((msk << (BW - IDW)) | msk)) | (hi << (BW - IDW)) | lo;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mode"}, 32'(MODE), 0);
      chk({tag, "_data"}, 32'(Data_Out), 0);
      chk({tag, "_mskb"}, 32'(Mskb_Out), 0);
      chk({tag, "_a"},    32'(A_Out), 0);
      chk({tag, "_dcs"},  32'(Dcs_Out), 0);
      chk({tag, "_vbe"},  32'(Vbe_Out), 0);
      chk({tag, "_vbi"},  32'(Vbi_Out), 0);
      chk({tag, "_pid"},  32'(PacketID_Out), 0);
      chk({tag, "_rvld"}, 32'(Rsp_Valid), 0);
      chk({tag, "_rdat"}, 32'(Rsp_Data), 0);
      chk({tag, "_ra"},   32'(Rsp_A), 0);
      chk({tag, "_rdy"},  32'(Req_Ready), 1);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_req(input int m, input int d, input int mk, input int a, input int dc,
                         input int ve, input int vi, input int ln, input int inc, input int hold);
      int nb, st, ea;
      chk("req_rdy", 32'(Req_Ready), 1);
      Req_Valid = 1'b1;  Req_Mode = 3'(m);  Req_Data = BW'(d);  Req_Mskb = BW'(mk);
      Req_A = AW'(a);    Req_Dcs = 1'(dc);  Req_Vbe = 1'(ve);   Req_Vbi = 1'(vi);
      Req_Len = 5'(ln);  Req_Inc = 1'(inc);
      @(posedge clk);
      @(negedge clk);
      Req_Valid = 1'b0;  Req_Mode = 3'($urandom);  Req_Data = BW'($urandom);  Req_A = AW'($urandom);
      if (m == 0 || m > 5) begin
         chk("drop_mode", 32'(MODE), 0);
         chk("drop_rdy", 32'(Req_Ready), 1);
         return;
      end
      nb = (m == 5 || ln == 0) ? 1 : ln;
      for (int b = 0; b < nb; b++) begin
         st = inc ? b : 0;
         ea = (a + b) % (1 << AW);
         chk("beat_mode", 32'(MODE), m);
         chk("beat_busy", 32'(Req_Ready), 0);
         chk("beat_dcs", 32'(Dcs_Out), dc);
         case (m)
            1: begin
               chk("w_a", 32'(A_Out), ea);
               chk("w_data", 32'(Data_Out), w_data(d, st));
               chk("w_mskb", 32'(Mskb_Out), mk);
               chk("w_vbe", 32'(Vbe_Out), ve);
               chk("w_vbi", 32'(Vbi_Out), vi);
            end
            3: chk("f_pid", 32'(PacketID_Out), ((d % (1 << IDW)) + st) % (1 << IDW));
            4: begin
               chk("c_data", 32'(Data_Out), (d + st) % (1 << BW));
               chk("c_mskb", 32'(Mskb_Out), mk);
            end
            5: chk("rst_pid", 32'(PacketID_Out), 0);
            default: begin
               chk("r_a", 32'(A_Out), ea);
               chk("r_vbe", 32'(Vbe_Out), ve);
            end
         endcase
         @(negedge clk);
         if (m == 2) begin
            for (int k = 0; k < RDL; k++) begin
               chk("rdwait_mode", 32'(MODE), 0);
               chk("rdwait_vld", 32'(Rsp_Valid), 0);
               @(negedge clk);
            end
            for (int k = 0; k <= hold; k++) begin
               chk("rsp_vld", 32'(Rsp_Valid), 1);
               chk("rsp_data", 32'(Rsp_Data), 32'(mem_d[AW'(ea)]));
               chk("rsp_vbo", 32'(Rsp_Vbo), 32'(mem_v[AW'(ea)]));
               chk("rsp_a", 32'(Rsp_A), ea);
               chk("rsp_mode", 32'(MODE), 0);
               if (k == hold) Rsp_Ready = 1'b1;
               @(negedge clk);
            end
            Rsp_Ready = 1'b0;
            chk("rsp_clear", 32'(Rsp_Valid), 0);
         end
      end
      chk("gap_mode", 32'(MODE), 0);
      chk("gap_data", 32'(Data_Out), 0);
      chk("gap_mskb", 32'(Mskb_Out), 0);
      chk("gap_a", 32'(A_Out), 0);
      chk("gap_vbe", 32'(Vbe_Out), 0);
      chk("gap_vbi", 32'(Vbi_Out), 0);
      chk("gap_dcs", 32'(Dcs_Out), dc);
      chk("gap_busy", 32'(Req_Ready), 0);
      @(negedge clk);
      chk("idle_rdy", 32'(Req_Ready), 1);
      chk("idle_mode", 32'(MODE), 0);
   endtask

   initial begin
      rst_n = 1'b0;  Req_Valid = 1'b0;  Req_Mode = 3'd0;  Req_Data = '0;  Req_Mskb = '0;
      Req_A = '0;  Req_Dcs = 1'b0;  Req_Vbe = 1'b0;  Req_Vbi = 1'b0;  Req_Len = 5'd0;
      Req_Inc = 1'b0;  Rsp_Ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_d[i] = BW'($urandom);
         mem_v[i] = 1'($urandom);
      end
      mem_d[1] = 8'hA5;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1, 'h00, 'hFF, 1, 1, 1, 1, 1, 0, 0);
      do_req(1, 'h31, 'h0F, 'hE, 0, 1, 0, 3, 1, 0);
      do_req(2, 'h00, 'h00, 1, 1, 1, 0, 2, 0, 3);
      do_req(3, 'h0E, 'h00, 0, 0, 0, 0, 3, 1, 0);
      do_req(7, 'h55, 'hAA, 3, 1, 1, 1, 4, 1, 0);
      do_req(5, 'h77, 'h00, 0, 1, 0, 0, 7, 0, 0);
      do_req(4, 'hFE, 'h3C, 0, 0, 0, 0, 0, 1, 0);

      for (int n = 0; n < 40; n++) begin
         do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
      end

      // Reset in beat 2 of a 4-beat compare burst.
`ifdef TCAM_CMD_COUNT_EN
      cnt0 = int'(Cmd_Count);
`endif
      Req_Valid = 1'b1;  Req_Mode = 3'd4;  Req_Data = 8'h20;  Req_Mskb = 8'hF0;
      Req_Dcs = 1'b1;  Req_Len = 5'd4;  Req_Inc = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Req_Valid = 1'b0;
      chk("cb1_mode", 32'(MODE), 4);
      @(negedge clk);
      chk("cb2_mode", 32'(MODE), 4);
      chk("cb2_data", 32'(Data_Out), 'h21);
`ifdef TCAM_CMD_COUNT_EN
      chk("cb2_count", 32'(Cmd_Count), (cnt0 + 2) % 65536);
`endif
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
`ifdef TCAM_CMD_COUNT_EN
      chk("midrst_count", 32'(Cmd_Count), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rdy", 32'(Req_Ready), 1);
      chk("post_mode", 32'(MODE), 0);

      // Reset while a read response is waiting for Rsp_Ready.
      Req_Valid = 1'b1;  Req_Mode = 3'd2;  Req_A = 4'd5;  Req_Len = 5'd3;
      @(posedge clk);
      @(negedge clk);
      Req_Valid = 1'b0;
      repeat (RDL + 1) @(negedge clk);
      chk("pend_vld", 32'(Rsp_Valid), 1);
      chk("pend_data", 32'(Rsp_Data), 32'(mem_d[5]));
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("pendrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("pend_post_vld", 32'(Rsp_Valid), 0);
      do_req(1, 'h12, 'h34, 'hF, 0, 1, 1, 2, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
